// File: rtl/freq_meter.sv
// freq_meter: measures the period and high-phase length of an asynchronous
// square wave, counting in clk cycles, edge to edge on synchronized rising edges.
//
// Parameters
//   N        width of the period / high-time counters and outputs
//   TIMEOUT  clk cycles without a rising edge before timeout is declared
//            (2 < TIMEOUT < 2**N)
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   reset      asynchronous reset, active low
//   xung_in    square wave under measurement, asynchronous to clk
//   period     last measured period in clk cycles
//   high_time  last measured high-phase length in clk cycles
//   valid      one-cycle pulse when period/high_time take a new measurement
//   timeout    sticky: no rising edge seen within TIMEOUT cycles
//   busy       high while a measurement is in progress
module freq_meter #(
    parameter int unsigned N       = 26,
    parameter int unsigned TIMEOUT = 50000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         xung_in,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         valid,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    // cnt reaches this value on the TIMEOUT-th cycle after the last edge
    localparam logic [N-1:0] CntLast = N'(TIMEOUT - 1);
    localparam logic [N-1:0] One     = N'(1);

    state_e       state;
    logic         s1, s2, s3;
    logic         rise;
    logic [N-1:0] cnt;
    logic [N-1:0] hcnt;

    // s1/s2 synchronize, s3 holds the previous synchronized value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= xung_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign busy = (state == StMeasure);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            cnt       <= '0;
            hcnt      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                StIdle: begin
                    // First edge only arms; there is no start reference yet.
                    if (rise) begin
                        state <= StMeasure;
                        cnt   <= '0;
                        hcnt  <= One;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        // Rise wins over a coincident timeout.
                        period    <= cnt + One;
                        high_time <= hcnt;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                        cnt       <= '0;
                        hcnt      <= One;
                    end else if (cnt == CntLast) begin
                        timeout   <= 1'b1;
                        period    <= '0;
                        high_time <= '0;
                        state     <= StIdle;
                    end else begin
                        cnt <= cnt + One;
                        if (s2) begin
                            hcnt <= hcnt + One;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
